isdu_ctrl: RTL and testbench



---
 rtl/isdu_pkg.sv | 60 ++++++
 rtl/mem_wait_ctr.sv | 33 +++
 rtl/isdu_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_isdu_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/isdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isdu_pkg
// Description : Shared state encoding and control-field encodings for the
//               SLC-3 instruction sequencing/decode unit.
// Revision    : 1.0
// ============================================================================
package isdu_pkg;

    typedef enum logic [4:0] {
        S_HALTED = 5'd0,
        S_18     = 5'd1,
        S_33     = 5'd2,
        S_35     = 5'd3,
        S_32     = 5'd4,
        S_1      = 5'd5,
        S_5      = 5'd6,
        S_9      = 5'd7,
        S_0      = 5'd8,
        S_22     = 5'd9,
        S_12     = 5'd10,
        S_4      = 5'd11,
        S_21     = 5'd12,
        S_20     = 5'd13,
        S_6      = 5'd14,
        S_25     = 5'd15,
        S_27     = 5'd16,
        S_7      = 5'd17,
        S_23     = 5'd18,
        S_16     = 5'd19,
        S_PAUSE1 = 5'd20,
        S_PAUSE2 = 5'd21
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

endpackage : isdu_pkg
`default_nettype wire

// File: rtl/mem_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_ctr
// Description : Loadable down-counter that stretches memory access states.
// Revision    : 1.0
// ============================================================================
module mem_wait_ctr #(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule : mem_wait_ctr
`default_nettype wire

// File: rtl/isdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : isdu_ctrl
// Description : SLC-3 fetch/decode/execute sequencer driving datapath controls.
// Revision    : 1.0
// ============================================================================
module isdu_ctrl
    import isdu_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       loadMAR,
    output logic       loadMDR,
    output logic       loadIR,
    output logic       loadBEN,
    output logic       loadCC,
    output logic       loadREG,
    output logic       loadPC,
    output logic       loadLED,
    output logic       gatePC,
    output logic       gateMDR,
    output logic       gateALU,
    output logic       gateMARMUX,
    output logic [1:0] PCMUXsel,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [2:0] c_wait_load = 3'(MEM_WAIT - 1);

    state_t r_state;
    logic   w_load;
    logic   w_dec;
    logic   w_done;

    // The counter is reloaded in the state that precedes each memory state.
    assign w_load = (r_state == S_18) || (r_state == S_6) || (r_state == S_23);
    assign w_dec  = (r_state == S_33) || (r_state == S_25) || (r_state == S_16);

    mem_wait_ctr #(
        .WIDTH    (3),
        .LOAD_VAL (c_wait_load)
    ) u_wait (
        .clk    (Clk),
        .rst    (Reset),
        .i_load (w_load),
        .i_dec  (w_dec),
        .o_done (w_done)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_HALTED;
        end else begin
            case (r_state)
                S_HALTED: if (Run) r_state <= S_18;
                S_18:     r_state <= S_33;
                S_33:     if (w_done) r_state <= S_35;
                S_35:     r_state <= S_32;
                S_32: begin
                    case (Opcode)
                        OP_ADD:   r_state <= S_1;
                        OP_AND:   r_state <= S_5;
                        OP_NOT:   r_state <= S_9;
                        OP_BR:    r_state <= S_0;
                        OP_JMP:   r_state <= S_12;
                        OP_JSR:   r_state <= S_4;
                        OP_LDR:   r_state <= S_6;
                        OP_STR:   r_state <= S_7;
                        OP_PAUSE: r_state <= S_PAUSE1;
                        default:  r_state <= S_18;
                    endcase
                end
                S_0:      r_state <= BEN ? S_22 : S_18;
                S_4:      r_state <= IR_11 ? S_21 : S_20;
                S_6:      r_state <= S_25;
                S_25:     if (w_done) r_state <= S_27;
                S_7:      r_state <= S_23;
                S_23:     r_state <= S_16;
                S_16:     if (w_done) r_state <= S_18;
                S_PAUSE1: if (Continue) r_state <= S_PAUSE2;
                S_PAUSE2: if (!Continue) r_state <= S_18;
                S_1, S_5, S_9, S_22, S_12, S_21, S_20, S_27: r_state <= S_18;
                default:  r_state <= S_HALTED;
            endcase
        end
    end

    always_comb begin
        loadMAR    = 1'b0;
        loadMDR    = 1'b0;
        loadIR     = 1'b0;
        loadBEN    = 1'b0;
        loadCC     = 1'b0;
        loadREG    = 1'b0;
        loadPC     = 1'b0;
        loadLED    = 1'b0;
        gatePC     = 1'b0;
        gateMDR    = 1'b0;
        gateALU    = 1'b0;
        gateMARMUX = 1'b0;
        PCMUXsel   = PCMUX_INC;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;
        case (r_state)
            S_18: begin
                gatePC  = 1'b1;
                loadMAR = 1'b1;
                loadPC  = 1'b1;
            end
            S_33, S_25: begin
                Mem_OE  = 1'b1;
                MIO_EN  = 1'b1;
                loadMDR = w_done;
            end
            S_35: begin
                gateMDR = 1'b1;
                loadIR  = 1'b1;
            end
            S_32: loadBEN = 1'b1;
            S_1, S_5, S_9: begin
                ALUK    = (r_state == S_1) ? ALUK_ADD :
                          (r_state == S_5) ? ALUK_AND : ALUK_NOT;
                SR1MUX  = 1'b1;
                SR2MUX  = (r_state == S_9) ? 1'b0 : IR_5;
                gateALU = 1'b1;
                loadREG = 1'b1;
                loadCC  = 1'b1;
            end
            S_22: begin
                ADDR2MUX = ADDR2_OFF9;
                PCMUXsel = PCMUX_ADDR;
                loadPC   = 1'b1;
            end
            S_12, S_20: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                PCMUXsel = PCMUX_ADDR;
                loadPC   = 1'b1;
            end
            S_4: begin
                gatePC  = 1'b1;
                DRMUX   = 1'b1;
                loadREG = 1'b1;
            end
            S_21: begin
                ADDR2MUX = ADDR2_OFF11;
                PCMUXsel = PCMUX_ADDR;
                loadPC   = 1'b1;
            end
            S_6, S_7: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_OFF6;
                gateMARMUX = 1'b1;
                loadMAR    = 1'b1;
            end
            S_27: begin
                gateMDR = 1'b1;
                loadREG = 1'b1;
                loadCC  = 1'b1;
            end
            S_23: begin
                ALUK    = ALUK_PASSA;
                gateALU = 1'b1;
                loadMDR = 1'b1;
            end
            S_16:     Mem_WE  = 1'b1;
            S_PAUSE1: loadLED = 1'b1;
            default: ;
        endcase
    end

endmodule : isdu_ctrl
`default_nettype wire

// File: tb/tb_isdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_isdu_ctrl
// Description : Randomized self-checking bench; one DUT per MEM_WAIT of 1..3.
// Revision    : 1.0
// ============================================================================
module tb_isdu_ctrl;

    typedef struct packed {
        logic       loadMAR, loadMDR, loadIR, loadBEN, loadCC, loadREG, loadPC, loadLED;
        logic       gatePC, gateMDR, gateALU, gateMARMUX;
        logic [1:0] PCMUXsel;
        logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
        logic [1:0] ADDR2MUX;
        logic [1:0] ALUK;
        logic       MIO_EN, Mem_OE, Mem_WE;
    } ctl_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = 4'h0;
    logic       IR_5 = 1'b0;
    logic       IR_11 = 1'b0;
    logic       BEN = 1'b0;
    ctl_t       obs [3];

    int   n_checks = 0;
    int   n_errors = 0;
    int   sel = 0;
    ctl_t q_exp[$];
    logic q_cont[$];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        isdu_ctrl #(.MEM_WAIT(g + 1)) u_dut (
            .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
            .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
            .loadMAR(obs[g].loadMAR), .loadMDR(obs[g].loadMDR), .loadIR(obs[g].loadIR),
            .loadBEN(obs[g].loadBEN), .loadCC(obs[g].loadCC), .loadREG(obs[g].loadREG),
            .loadPC(obs[g].loadPC), .loadLED(obs[g].loadLED), .gatePC(obs[g].gatePC),
            .gateMDR(obs[g].gateMDR), .gateALU(obs[g].gateALU), .gateMARMUX(obs[g].gateMARMUX),
            .PCMUXsel(obs[g].PCMUXsel), .DRMUX(obs[g].DRMUX), .SR1MUX(obs[g].SR1MUX),
            .SR2MUX(obs[g].SR2MUX), .ADDR1MUX(obs[g].ADDR1MUX), .ADDR2MUX(obs[g].ADDR2MUX),
            .ALUK(obs[g].ALUK), .MIO_EN(obs[g].MIO_EN), .Mem_OE(obs[g].Mem_OE),
            .Mem_WE(obs[g].Mem_WE)
        );
    end

    task automatic chk(input string tag, input ctl_t got, input ctl_t want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s mw=%0d got=%07h want=%07h", tag, sel + 1, got, want);
        end
    endtask

    task automatic push(input ctl_t e, input logic c);
        q_exp.push_back(e);
        q_cont.push_back(c);
    endtask

    task automatic push_read(input int mw);
        ctl_t e;
        for (int i = 0; i < mw; i++) begin
            e = '0; e.Mem_OE = 1'b1; e.MIO_EN = 1'b1; e.loadMDR = (i == mw - 1);
            push(e, 1'($urandom));
        end
    endtask

    // Expected cycle-by-cycle control words for one whole instruction, fetch included.
    task automatic build(input int mw, input logic [3:0] op, input logic ir5,
                         input logic ir11, input logic ben, input int a, input int b);
        ctl_t e;
        ctl_t jmp;
        jmp = '0; jmp.SR1MUX = 1; jmp.ADDR1MUX = 1; jmp.PCMUXsel = 2'b10; jmp.loadPC = 1;
        e = '0; e.gatePC = 1; e.loadMAR = 1; e.loadPC = 1; push(e, 1'($urandom));
        push_read(mw);
        e = '0; e.gateMDR = 1; e.loadIR = 1; push(e, 1'($urandom));
        e = '0; e.loadBEN = 1; push(e, 1'($urandom));
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                e = '0; e.SR1MUX = 1; e.gateALU = 1; e.loadREG = 1; e.loadCC = 1;
                e.ALUK = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
                e.SR2MUX = (op == 4'b1001) ? 1'b0 : ir5;
                push(e, 1'($urandom));
            end
            4'b0000: begin
                push('0, 1'($urandom));
                if (ben) begin
                    e = '0; e.ADDR2MUX = 2'b10; e.PCMUXsel = 2'b10; e.loadPC = 1;
                    push(e, 1'($urandom));
                end
            end
            4'b1100: push(jmp, 1'($urandom));
            4'b0100: begin
                e = '0; e.gatePC = 1; e.DRMUX = 1; e.loadREG = 1; push(e, 1'($urandom));
                if (ir11) begin
                    e = '0; e.ADDR2MUX = 2'b11; e.PCMUXsel = 2'b10; e.loadPC = 1;
                    push(e, 1'($urandom));
                end else begin
                    push(jmp, 1'($urandom));
                end
            end
            4'b0110, 4'b0111: begin
                e = '0; e.SR1MUX = 1; e.ADDR1MUX = 1; e.ADDR2MUX = 2'b01;
                e.gateMARMUX = 1; e.loadMAR = 1; push(e, 1'($urandom));
                if (op == 4'b0110) begin
                    push_read(mw);
                    e = '0; e.gateMDR = 1; e.loadREG = 1; e.loadCC = 1; push(e, 1'($urandom));
                end else begin
                    e = '0; e.ALUK = 2'b11; e.gateALU = 1; e.loadMDR = 1; push(e, 1'($urandom));
                    for (int i = 0; i < mw; i++) begin
                        e = '0; e.Mem_WE = 1; push(e, 1'($urandom));
                    end
                end
            end
            4'b1101: begin
                e = '0; e.loadLED = 1;
                for (int i = 0; i <= a; i++) push(e, (i == a));
                for (int i = 0; i <= b; i++) push('0, (i != b));
            end
            default: ;
        endcase
    endtask

    // Entered just after a clock edge with the DUT sitting in the fetch state.
    task automatic run_instr(input logic [3:0] op, input logic ir5, input logic ir11,
                             input logic ben, input int a, input int b);
        Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
        build(sel + 1, op, ir5, ir11, ben, a, b);
        for (int i = 0; i < q_exp.size(); i++) begin
            chk($sformatf("op%0h_c%0d", op, i), obs[sel], q_exp[i]);
            Continue = q_cont[i];
            Run = 1'($urandom);
            @(posedge Clk); #1;
        end
        q_exp.delete();
        q_cont.delete();
    endtask

    task automatic reset_and_start();
        Reset = 1'b1; Run = 1'b0;
        #1 chk("reset", obs[sel], '0);
        @(negedge Clk); Reset = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
            chk("halted", obs[sel], '0);
        end
        Run = 1'b1;
        @(posedge Clk); #1;
        Run = 1'b0;
    endtask

    initial begin
        ctl_t e;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            reset_and_start();
            run_instr(4'b0001, 1, 0, 0, 0, 0);
            run_instr(4'b0000, 0, 0, 0, 0, 0);
            run_instr(4'b0000, 1, 1, 1, 0, 0);
            run_instr(4'b0100, 0, 0, 1, 0, 0);
            run_instr(4'b0100, 1, 1, 0, 0, 0);
            run_instr(4'b0111, 0, 0, 0, 0, 0);
            run_instr(4'b0110, 0, 0, 0, 0, 0);
            run_instr(4'b1101, 0, 0, 0, 10, 4);
            run_instr(4'b1111, 0, 0, 0, 0, 0);
            for (int k = 0; k < 40; k++) begin
                run_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                          $urandom_range(0, 5), $urandom_range(0, 5));
            end
            // Reset in the middle of a memory read must clear the strobes at once.
            Continue = 1'b0;
            @(posedge Clk); #1;
            e = '0; e.Mem_OE = 1; e.MIO_EN = 1; e.loadMDR = (s == 0);
            chk("rd_before_rst", obs[sel], e);
            #2 Reset = 1'b1;
            #1 chk("rst_mid_read", obs[sel], '0);
            @(posedge Clk); #1;
            chk("rst_held", obs[sel], '0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_isdu_ctrl
`default_nettype wire
